// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that serialises iCache and dCache line-fill
// misses onto a single memory port and returns each fetched line to its owner
// with a one-cycle ready pulse. Every output is a register or a decode of the
// state register, so no input reaches an output combinationally.
module mem_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int LINE_SIZE   = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IReq,
  input  logic [WORD_SIZE-1:0] IAddr,
  output logic [LINE_SIZE-1:0] ILine,
  output logic                 IReady,
  input  logic                 DReq,
  input  logic [WORD_SIZE-1:0] DAddr,
  output logic [LINE_SIZE-1:0] DLine,
  output logic                 DReady,
  output logic                 MemReq,
  output logic [WORD_SIZE-1:0] MemAddr,
  input  logic [LINE_SIZE-1:0] MemLine,
  input  logic                 MemAck
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Which cache a grant or a completed fill belongs to.
  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  // Clears the byte-offset bits so memory always sees a line-aligned address.
  function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] addr);
    logic [WORD_SIZE-1:0] mask;
    mask = {WORD_SIZE{1'b1}} << OFFSET_BITS;
    return addr & mask;
  endfunction

  state_t                 state_r;
  state_t                 next_state_s;
  side_t                  last_grant_r;
  side_t                  owner_r;
  side_t                  grant_side_s;
  logic                   grant_valid_s;
  logic                   fill_done_s;
  logic [WORD_SIZE-1:0]   sel_addr_s;
  logic [WORD_SIZE-1:0]   addr_r;
  logic [LINE_SIZE-1:0]   line_r;

  // Next-state and grant decision; requests are only looked at in IDLE.
  always_comb begin
    next_state_s  = state_r;
    grant_valid_s = 1'b0;
    grant_side_s  = SIDE_I;
    fill_done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (IReq && DReq) begin
          grant_valid_s = 1'b1;
          if (last_grant_r == SIDE_I) begin
            grant_side_s = SIDE_D;
            next_state_s = BUSY_D;
          end else begin
            grant_side_s = SIDE_I;
            next_state_s = BUSY_I;
          end
        end else if (IReq) begin
          grant_valid_s = 1'b1;
          grant_side_s  = SIDE_I;
          next_state_s  = BUSY_I;
        end else if (DReq) begin
          grant_valid_s = 1'b1;
          grant_side_s  = SIDE_D;
          next_state_s  = BUSY_D;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY_I: begin
        if (MemAck) begin
          fill_done_s  = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY_I;
        end
      end
      BUSY_D: begin
        if (MemAck) begin
          fill_done_s  = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY_D;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Address of whichever requester is being granted this cycle.
  always_comb begin
    if (grant_side_s == SIDE_D) begin
      sel_addr_s = DAddr;
    end else begin
      sel_addr_s = IAddr;
    end
  end

  // State register; reset discards any fill in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant bookkeeping: aligned address and round-robin pointer, updated on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r       <= {WORD_SIZE{1'b0}};
      last_grant_r <= SIDE_I;
    end else if (grant_valid_s) begin
      addr_r       <= line_align(sel_addr_s);
      last_grant_r <= grant_side_s;
    end else begin
      addr_r       <= addr_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Fill capture: MemLine and the owning side are taken only on an ack while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r  <= {LINE_SIZE{1'b0}};
      owner_r <= SIDE_I;
    end else if (fill_done_s) begin
      line_r  <= MemLine;
      owner_r <= (state_r == BUSY_D) ? SIDE_D : SIDE_I;
    end else begin
      line_r  <= line_r;
      owner_r <= owner_r;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    MemReq  = (state_r == BUSY_I) || (state_r == BUSY_D);
    MemAddr = addr_r;
    IReady  = (state_r == RESP) && (owner_r == SIDE_I);
    DReady  = (state_r == RESP) && (owner_r == SIDE_D);
    ILine   = line_r;
    DLine   = line_r;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. The bench plays the memory
// model; each ack pushes the expected (owner, line) pair and a negedge monitor
// pops it when a Ready pulse appears.
module tb_mem_arbiter;

  localparam int WS = 32;
  localparam int LS = 128;

  localparam logic [LS-1:0] LINE_T1 = 128'h1111_1111_2222_2222_3333_3333_4444_4401;
  localparam logic [LS-1:0] LINE_T2 = 128'h5555_5555_6666_6666_7777_7777_8888_8802;
  localparam logic [LS-1:0] LINE_T3 = 128'h9999_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FF03;
  localparam logic [LS-1:0] LINE_T4 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3204;
  localparam logic [LS-1:0] LINE_DA = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0001;
  localparam logic [LS-1:0] LINE_IB = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_0B0B;
  localparam logic [LS-1:0] LINE_DC = 128'hCAFE_F00D_5A5A_A5A5_0F0F_F0F0_1234_0C0C;
  localparam logic [LS-1:0] LINE_ID = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_0D0D;
  localparam logic [LS-1:0] LINE_XE = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [LS-1:0] LINE_XF = 128'h7E57_7E57_7E57_7E57_7E57_7E57_7E57_7E57;

  logic          clk = 1'b0;
  logic          rst;
  logic          IReq;
  logic [WS-1:0] IAddr;
  logic [LS-1:0] ILine;
  logic          IReady;
  logic          DReq;
  logic [WS-1:0] DAddr;
  logic [LS-1:0] DLine;
  logic          DReady;
  logic          MemReq;
  logic [WS-1:0] MemAddr;
  logic [LS-1:0] MemLine;
  logic          MemAck;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic          side;   // 0 = I, 1 = D
    logic [LS-1:0] line;
  } sb_item_t;

  sb_item_t sb_q[$];

  mem_arbiter #(
    .WORD_SIZE  (WS),
    .LINE_SIZE  (LS),
    .OFFSET_BITS(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .IReq   (IReq),
    .IAddr  (IAddr),
    .ILine  (ILine),
    .IReady (IReady),
    .DReq   (DReq),
    .DAddr  (DAddr),
    .DLine  (DLine),
    .DReady (DReady),
    .MemReq (MemReq),
    .MemAddr(MemAddr),
    .MemLine(MemLine),
    .MemAck (MemAck)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [LS-1:0] got, input logic [LS-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every output must read zero (reset state).
  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_memreq"},  LS'(MemReq),  LS'(1'b0));
    check_eq({tag, "_memaddr"}, LS'(MemAddr), LS'(32'h0));
    check_eq({tag, "_iready"},  LS'(IReady),  LS'(1'b0));
    check_eq({tag, "_dready"},  LS'(DReady),  LS'(1'b0));
    check_eq({tag, "_iline"},   ILine,        {LS{1'b0}});
    check_eq({tag, "_dline"},   DLine,        {LS{1'b0}});
  endtask

  // Quiet cycles: no memory request, and both line outputs hold exp_line.
  task automatic idle_cycles(input int n, input logic [LS-1:0] exp_line);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_memreq", LS'(MemReq), LS'(1'b0));
      check_eq("idle_iline",  ILine, exp_line);
      check_eq("idle_dline",  DLine, exp_line);
    end
  endtask

  // Memory model for one fill: wait for MemReq, check the address, hold off
  // 'delay' cycles, then ack with 'line' and log the expected Ready.
  // 'gap' returns how many negedges MemReq was seen low before it rose.
  task automatic serve_fill(input logic side, input logic [WS-1:0] addr, input int delay,
                            input logic [LS-1:0] line, output int gap);
    sb_item_t item;
    gap = 0;
    while (!MemReq && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check_eq("memreq_rise", LS'(MemReq),  LS'(1'b1));
    check_eq("mem_addr",    LS'(MemAddr), LS'(addr));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq("memreq_hold",   LS'(MemReq),  LS'(1'b1));
      check_eq("memaddr_hold",  LS'(MemAddr), LS'(addr));
    end
    MemAck    = 1'b1;
    MemLine   = line;
    item.side = side;
    item.line = line;
    sb_q.push_back(item);
    @(negedge clk);
    MemAck  = 1'b0;
    MemLine = ~line;
    check_eq("memreq_resp_low", LS'(MemReq), LS'(1'b0));
  endtask

  // Scoreboard monitor: every Ready pulse must match the oldest expected fill.
  always @(negedge clk) begin
    sb_item_t exp_item;
    if (IReady || DReady) begin
      check_eq("ready_onehot", LS'(IReady & DReady), LS'(1'b0));
      if (sb_q.size() == 0) begin
        check_eq("stray_ready", LS'({IReady, DReady}), LS'(2'b00));
      end else begin
        exp_item = sb_q.pop_front();
        check_eq("ready_side", LS'({IReady, DReady}),
                 LS'(exp_item.side ? 2'b01 : 2'b10));
        check_eq("ready_iline", ILine, exp_item.line);
        check_eq("ready_dline", DLine, exp_item.line);
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int gap;
    rst     = 1'b1;
    IReq    = 1'b0;
    IAddr   = 32'h0;
    DReq    = 1'b0;
    DAddr   = 32'h0;
    MemLine = {LS{1'b0}};
    MemAck  = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");

    // Tie straight after reset: D first, then strict I/D alternation.
    rst   = 1'b0;
    IReq  = 1'b1;
    IAddr = 32'h0000_4008;
    DReq  = 1'b1;
    DAddr = 32'h0000_800C;
    serve_fill(1'b1, 32'h0000_8000, 0, LINE_T1, gap);
    check_eq("tie_first_latency", LS'(gap), LS'(32'd1));
    serve_fill(1'b0, 32'h0000_4000, 1, LINE_T2, gap);
    check_eq("tie_gap2", LS'(gap), LS'(32'd2));
    serve_fill(1'b1, 32'h0000_8000, 0, LINE_T3, gap);
    check_eq("tie_gap3", LS'(gap), LS'(32'd2));
    serve_fill(1'b0, 32'h0000_4000, 0, LINE_T4, gap);
    check_eq("tie_gap4", LS'(gap), LS'(32'd2));
    IReq = 1'b0;
    DReq = 1'b0;
    idle_cycles(3, LINE_T4);

    // Single D miss with memory acking two cycles into BUSY.
    DReq  = 1'b1;
    DAddr = 32'h0000_1234;
    serve_fill(1'b1, 32'h0000_1230, 2, LINE_DA, gap);
    DReq = 1'b0;
    idle_cycles(3, LINE_DA);

    // DReq rises while an I fill is in flight; D follows with its own address.
    IReq  = 1'b1;
    IAddr = 32'h0000_2A5F;
    repeat (2) @(negedge clk);
    DReq  = 1'b1;
    DAddr = 32'h0000_7777;
    serve_fill(1'b0, 32'h0000_2A50, 2, LINE_IB, gap);
    IReq = 1'b0;
    serve_fill(1'b1, 32'h0000_7770, 0, LINE_DC, gap);
    check_eq("midbusy_gap", LS'(gap), LS'(32'd2));
    DReq = 1'b0;
    idle_cycles(2, LINE_DC);

    // IReq dropped mid-fill: request to memory stays up and IReady still pulses.
    IReq  = 1'b1;
    IAddr = 32'h0000_0F00;
    repeat (2) @(negedge clk);
    IReq = 1'b0;
    serve_fill(1'b0, 32'h0000_0F00, 3, LINE_ID, gap);
    idle_cycles(3, LINE_ID);

    // Stray MemAck in IDLE must not load the line or pulse Ready.
    MemAck  = 1'b1;
    MemLine = LINE_XE;
    @(negedge clk);
    MemAck  = 1'b0;
    MemLine = {LS{1'b0}};
    idle_cycles(3, LINE_ID);

    // Reset during BUSY_D, then a late MemAck that must be ignored.
    DReq  = 1'b1;
    DAddr = 32'h0000_3338;
    repeat (2) @(negedge clk);
    check_eq("rstbusy_memreq",  LS'(MemReq),  LS'(1'b1));
    check_eq("rstbusy_memaddr", LS'(MemAddr), LS'(32'h0000_3330));
    rst  = 1'b1;
    DReq = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_rst");
    rst     = 1'b0;
    MemAck  = 1'b1;
    MemLine = LINE_XF;
    @(negedge clk);
    MemAck  = 1'b0;
    check_outputs_zero("late_ack");
    repeat (2) begin
      @(negedge clk);
      check_outputs_zero("post_rst_idle");
    end

    check_eq("sb_drained", LS'(sb_q.size()), LS'(32'd0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter between the instruction cache and data cache miss ports. It accepts line-fill requests from both caches and serialises them onto the single memory port. Ties are resolved round-robin, and each fetched line is returned to the granted cache with a one-cycle ready pulse. It sits between the two caches and the memory model, replacing the direct cache-to-memory wiring.

## Interface
- WORD_SIZE, 32, address width in bits
- LINE_SIZE, 128, cache line width in bits
- OFFSET_BITS, 4, byte-offset bits within a line; these are cleared on the memory address
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- IReq  in  1  iCache miss request, held until IReady
- IAddr  in  WORD_SIZE  iCache miss address
- ILine  out  LINE_SIZE  returned line for iCache
- IReady  out  1  one-cycle pulse: ILine valid for iCache
- DReq  in  1  dCache miss request, held until DReady
- DAddr  in  WORD_SIZE  dCache miss address
- DLine  out  LINE_SIZE  returned line for dCache
- DReady  out  1  one-cycle pulse: DLine valid for dCache
- MemReq  out  1  request to memory, held until MemAck
- MemAddr  out  WORD_SIZE  line-aligned memory address
- MemLine  in  LINE_SIZE  line data from memory, valid with MemAck
- MemAck  in  1  memory completion, one cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - IReq only → BUSY_I; DReq only → BUSY_D.
  - IReq and DReq together → grant the side not in last_grant, then update last_grant.
  - last_grant resets to I, so D wins the first tie.
- On entering BUSY_x:
  - Latch the requester address with the low OFFSET_BITS zeroed into addr_reg.
  - MemAddr = addr_reg and MemReq = 1 for the whole BUSY state.
- BUSY_x:
  - On MemAck, latch MemLine into line_reg, record owner = x, and go to RESP.
  - Otherwise stay; there is no timeout.
- RESP, one cycle:
  - xReady = 1 for the owner only; MemReq = 0.
  - IReq/DReq are ignored this cycle, so a requester still holding Req is not regranted.
  - Always → IDLE.
- ILine and DLine are both driven from line_reg and hold their value between fills.
- A requester deasserting Req mid-transaction does not abort it. The fill completes and Ready still pulses; caches tolerate a stray Ready.
- MemAck in IDLE or RESP is ignored.
- Address and request inputs of the non-granted requester are not sampled until the next IDLE.

## Timing
- Reset values: state IDLE, last_grant I, addr_reg 0, line_reg 0. All outputs 0: MemReq, MemAddr, IReady, DReady, ILine, DLine.
- rst is asserted in any state → IDLE next edge, all outputs 0, and any in-flight fill is discarded. A MemAck arriving later is ignored.
- Latency:
  - Req sampled high in IDLE at edge t → MemReq high from after edge t.
  - MemAck sampled at edge m → Ready high for the cycle after edge m.
  - Earliest next grant is edge m+2.
- With memory acking in the first BUSY cycle, minimum turnaround is 3 cycles per fill (IDLE, BUSY, RESP).
- Back-to-back: a waiting requester is granted in the IDLE cycle following RESP. Two-way contention therefore alternates strictly I/D.
- All outputs are registered or decoded from the state register only; no combinational path from any input to any output.

## Test plan
- Single D miss:
  - Stimulus: DReq=1, DAddr=0x0000_1234; memory acks 2 cycles later with MemLine=0xAAAA…0001.
  - Required: MemAddr=0x0000_1230 with MemReq high; DReady pulses once; DLine=0xAAAA…0001; IReady stays 0.
- Simultaneous IReq/DReq straight after reset, both held:
  - Required: D serviced first, then I, then D, then I.
  - MemReq low exactly one RESP cycle and one IDLE cycle between fills.
- I miss in flight, DReq rises mid-BUSY_I:
  - Required: I fill completes undisturbed, IReady pulses.
  - Grant to D follows in the next IDLE, with D's address, not I's.
- Requester drops IReq during BUSY_I:
  - Required: MemReq stays high until MemAck; IReady still pulses; FSM returns to IDLE.
- rst asserted while BUSY_D, then MemAck pulses in the following cycle:
  - Required: all outputs 0 after the rst edge; DReady never pulses; FSM stays IDLE.
- Stray MemAck in IDLE with no requests:
  - Required: no Ready pulse; line_reg unchanged (ILine/DLine keep prior value).
